// File: rtl/dmem_access.sv
// Memory-stage data-memory controller: issues one request per instruction, stalls until the
// response arrives, then aligns/extends load data. Optional watchdog guarded by DMEM_TIMEOUT_EN.
`timescale 1ns/1ps

module dmem_access #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_rmask,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load_op,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [31:0] mem_rdata_raw,
    output logic        spurious_resp,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    state_e      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  load_op_q, load_op_d;
    logic        store_q, store_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] raw_q, raw_d;
    logic        spurious_q, spurious_d;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            OP_LW:   r = rd;
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        load_op_d   = load_op_q;
        store_d     = store_q;
        load_data_d = load_data_q;
        raw_d       = raw_q;
        spurious_d  = spurious_q;
        dmem_addr   = 32'h0;
        dmem_rmask  = 4'h0;
        dmem_wmask  = 4'h0;
        dmem_wdata  = 32'h0;
        stall       = 1'b0;
        done        = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dmem_addr  = {req_addr[31:2], 2'b00};
                    dmem_rmask = req_rmask;
                    dmem_wmask = req_wmask;
                    dmem_wdata = req_wdata;
                    stall      = 1'b1;
                    addr_lo_d  = req_addr[1:0];
                    load_op_d  = req_load_op;
                    store_d    = |req_wmask;
                    state_d    = WAIT;
`ifdef DMEM_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_resp) begin
                    raw_d       = dmem_rdata;
                    load_data_d = store_q ? 32'h0 : extend_load(load_op_q, addr_lo_q, dmem_rdata);
                    state_d     = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                // Give up after WAIT_LIMIT silent cycles so the pipeline can drain.
                else if (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0;
                    raw_d       = 32'h0;
                    state_d     = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only a response in WAIT is legal; anything else is flagged and dropped.
        if (dmem_resp && (state_q != WAIT)) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'b00;
            load_op_q   <= 3'b000;
            store_q     <= 1'b0;
            load_data_q <= 32'h0;
            raw_q       <= 32'h0;
            spurious_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            load_op_q   <= load_op_d;
            store_q     <= store_d;
            load_data_q <= load_data_d;
            raw_q       <= raw_d;
            spurious_q  <= spurious_d;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign load_data     = load_data_q;
    assign mem_rdata_raw = raw_q;
    assign spurious_resp = spurious_q;
`ifdef DMEM_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: a transaction-timeline model predicts every output each cycle,
// driven by directed accesses plus randomized loads/stores, response delays and stray responses.
`timescale 1ns/1ps

module tb_dmem_access;

    localparam int unsigned WAIT_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_rmask;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic [2:0]  req_load_op;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic [31:0] mem_rdata_raw;
    logic        spurious_resp;
    logic        timeout;

    always #5 clk = ~clk;

    dmem_access #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_rmask     (req_rmask),
        .req_wmask     (req_wmask),
        .req_wdata     (req_wdata),
        .req_load_op   (req_load_op),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .stall         (stall),
        .done          (done),
        .load_data     (load_data),
        .mem_rdata_raw (mem_rdata_raw),
        .spurious_resp (spurious_resp),
        .timeout       (timeout)
    );

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic [2:0] load_ops [5] = '{LB, LH, LW, LBU, LHU};

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr, exp_wdata, exp_load, exp_raw;
    logic [3:0]  exp_rmask, exp_wmask;
    logic        exp_stall, exp_done, exp_spur, exp_timeout;
    bit          stray_now;
    bit          check_en;
    logic [31:0] seen_load;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference load result computed with plain shifts and arithmetic
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rd, input bit is_store);
        logic [31:0] b;
        logic [31:0] h;
        if (is_store) return 32'h0;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            LHU:     return h;
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("dmem_addr",     dmem_addr,          exp_addr);
            checkOutput("dmem_rmask",    32'(dmem_rmask),    32'(exp_rmask));
            checkOutput("dmem_wmask",    32'(dmem_wmask),    32'(exp_wmask));
            checkOutput("dmem_wdata",    dmem_wdata,         exp_wdata);
            checkOutput("stall",         32'(stall),         32'(exp_stall));
            checkOutput("done",          32'(done),          32'(exp_done));
            checkOutput("spurious_resp", 32'(spurious_resp), 32'(exp_spur));
            checkOutput("timeout",       32'(timeout),       32'(exp_timeout));
            if (exp_done || !rst_n) begin
                checkOutput("load_data",     load_data,     exp_load);
                checkOutput("mem_rdata_raw", mem_rdata_raw, exp_raw);
            end
            if (exp_done) seen_load = load_data;
        end
    end

    task automatic step();
        @(posedge clk);
        if (stray_now) exp_spur = 1'b1;
        stray_now = 1'b0;
        #1;
    endtask

    task automatic clearExp();
        exp_addr  = 32'h0;
        exp_rmask = 4'h0;
        exp_wmask = 4'h0;
        exp_wdata = 32'h0;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
    endtask

    // One complete instruction: issue, k-cycle wait, done; req_valid stays high throughout
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] rmask,
                                 input logic [3:0] wmask, input logic [31:0] wdata,
                                 input logic [2:0] op, input logic [31:0] rdata, input int k,
                                 input bit early_resp, input bit late_stray);
        req_valid   = 1'b1;
        req_addr    = addr;
        req_rmask   = rmask;
        req_wmask   = wmask;
        req_wdata   = wdata;
        req_load_op = op;
        dmem_resp   = early_resp;
        dmem_rdata  = $urandom;
        if (early_resp) stray_now = 1'b1;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_rmask = rmask;
        exp_wmask = wmask;
        exp_wdata = wdata;
        exp_stall = 1'b1;
        exp_done  = 1'b0;
        step();
        exp_addr  = 32'h0;
        exp_rmask = 4'h0;
        exp_wmask = 4'h0;
        exp_wdata = 32'h0;
        for (int j = 1; j <= k; j++) begin
            dmem_resp  = (j == k);
            dmem_rdata = (j == k) ? rdata : $urandom;
            step();
        end
        exp_stall  = 1'b0;
        exp_done   = 1'b1;
        exp_load   = model_load(op, addr[1:0], rdata, wmask != 4'h0);
        exp_raw    = rdata;
        dmem_resp  = late_stray;
        dmem_rdata = $urandom;
        if (late_stray) stray_now = 1'b1;
        step();
        exp_done  = 1'b0;
        dmem_resp = 1'b0;
    endtask

    task automatic idleCycles(input int n, input bit allow_stray);
        req_valid = 1'b0;
        req_rmask = 4'h0;
        req_wmask = 4'h0;
        for (int i = 0; i < n; i++) begin
            dmem_resp  = allow_stray && ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            if (dmem_resp) stray_now = 1'b1;
            step();
        end
        dmem_resp = 1'b0;
    endtask

    task automatic randomTxn();
        int          kind;
        int          k;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rm;
        logic [3:0]  wm;
        kind  = $urandom_range(0, 9);
        op    = load_ops[$urandom_range(0, 4)];
        addr  = $urandom;
        wdata = 32'h0;
        rm    = 4'h0;
        wm    = 4'h0;
        if (kind < 6) begin
            if (op == LH || op == LHU) addr[0] = 1'b0;
            if (op == LW) addr[1:0] = 2'b00;
            if (op == LB || op == LBU)      rm = 4'(4'b0001 << addr[1:0]);
            else if (op == LH || op == LHU) rm = addr[1] ? 4'b1100 : 4'b0011;
            else                            rm = 4'b1111;
        end else if (kind < 9) begin
            wdata = $urandom;
            case ($urandom_range(0, 2))
                0:       wm = 4'(4'b0001 << addr[1:0]);
                1:       begin addr[0] = 1'b0; wm = addr[1] ? 4'b1100 : 4'b0011; end
                default: begin addr[1:0] = 2'b00; wm = 4'b1111; end
            endcase
        end
        k = $urandom_range(1, 6);
        applyStimulus(addr, rm, wm, wdata, op, $urandom, k,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_rmask   = 4'h0;
        req_wmask   = 4'h0;
        req_wdata   = 32'h0;
        req_load_op = 3'b000;
        dmem_rdata  = 32'h0;
        dmem_resp   = 1'b0;
        stray_now   = 1'b0;
        exp_spur    = 1'b0;
        exp_timeout = 1'b0;
        exp_load    = 32'h0;
        exp_raw     = 32'h0;
        seen_load   = 32'h0;
        clearExp();
        check_en    = 1'b1;

        checkOutput("model_lb",  model_load(LB,  2'd3, 32'h80FF_0000, 1'b0), 32'hFFFF_FF80);
        checkOutput("model_lbu", model_load(LBU, 2'd3, 32'h80FF_0000, 1'b0), 32'h0000_0080);
        checkOutput("model_lh",  model_load(LH,  2'd2, 32'h8001_1234, 1'b0), 32'hFFFF_8001);
        checkOutput("model_lhu", model_load(LHU, 2'd2, 32'h8001_1234, 1'b0), 32'h0000_8001);

        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed back-to-back accesses with req_valid held through DONE
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_1000, 4'b1111, 4'b0000, 32'h0, LW, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        checkOutput("lw_result", seen_load, 32'hDEAD_BEEF);
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_1003, 4'b1000, 4'b0000, 32'h0, LB, 32'h80FF_0000, 2, 1'b0, 1'b0);
        checkOutput("lb_result", seen_load, 32'hFFFF_FF80);
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_1003, 4'b1000, 4'b0000, 32'h0, LBU, 32'h80FF_0000, 1, 1'b0, 1'b0);
        checkOutput("lbu_result", seen_load, 32'h0000_0080);
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_1002, 4'b1100, 4'b0000, 32'h0, LH, 32'h8001_1234, 3, 1'b0, 1'b0);
        checkOutput("lh_result", seen_load, 32'hFFFF_8001);
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_1002, 4'b1100, 4'b0000, 32'h0, LHU, 32'h8001_1234, 1, 1'b0, 1'b0);
        checkOutput("lhu_result", seen_load, 32'h0000_8001);
        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_2001, 4'b0000, 4'b0010, 32'h0000_AB00, LB, 32'h1234_5678, 5, 1'b0, 1'b0);
        checkOutput("sb_result", seen_load, 32'h0000_0000);
        applyStimulus(32'h0000_2004, 4'b0000, 4'b1111, 32'hCAFE_F00D, LW, 32'h0, 1, 1'b0, 1'b0);
        checkOutput("spurious_clean", 32'(spurious_resp), 32'h0);

        // Lone stray response while idle
        idleCycles(1, 1'b0);
        dmem_resp = 1'b1;
        stray_now = 1'b1;
        step();
        dmem_resp = 1'b0;
        step();
        checkOutput("stray_sets_spurious", 32'(spurious_resp), 32'h1);

        rst_n    = 1'b0;
        exp_spur = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 60; t++) begin
            randomTxn();
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3), 1'b1);
        end

`ifdef DMEM_TIMEOUT_EN
        // No response at all: watchdog forces DONE with zeroed results
        idleCycles(1, 1'b0);
        req_valid = 1'b1; req_addr = 32'h3000; req_rmask = 4'hF; req_wmask = 4'h0;
        req_wdata = 32'h0; req_load_op = LW;
        exp_addr = 32'h3000; exp_rmask = 4'hF; exp_stall = 1'b1;
        step();
        exp_addr = 32'h0; exp_rmask = 4'h0;
        for (int j = 0; j < int'(WAIT_LIMIT); j++) step();
        exp_stall = 1'b0; exp_done = 1'b1; exp_load = 32'h0; exp_raw = 32'h0; exp_timeout = 1'b1;
        step();
        exp_done = 1'b0;
        checkOutput("timeout_set", 32'(timeout), 32'h1);
        idleCycles(1, 1'b0);
        dmem_resp = 1'b1; stray_now = 1'b1;
        step();
        dmem_resp = 1'b0;
        step();
        checkOutput("late_after_timeout", 32'(spurious_resp), 32'h1);
`endif

        // Reset in the middle of WAIT, then the orphaned response arrives
        idleCycles(1, 1'b0);
        req_valid = 1'b1; req_addr = 32'h4008; req_rmask = 4'hF; req_wmask = 4'h0;
        req_wdata = 32'h0; req_load_op = LW;
        exp_addr = 32'h4008; exp_rmask = 4'hF; exp_stall = 1'b1;
        step();
        exp_addr = 32'h0; exp_rmask = 4'h0;
        step();
        #1;
        clearExp();
        exp_spur    = 1'b0;
        exp_timeout = 1'b0;
        exp_load    = 32'h0;
        exp_raw     = 32'h0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        #1;
        checkOutput("rst_stall",     32'(stall),      32'h0);
        checkOutput("rst_rmask",     32'(dmem_rmask), 32'h0);
        checkOutput("rst_load_data", load_data,       32'h0);
        checkOutput("rst_raw",       mem_rdata_raw,   32'h0);
        step();
        rst_n = 1'b1;
        step();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        stray_now  = 1'b1;
        step();
        dmem_resp = 1'b0;
        step();
        checkOutput("orphan_resp_spurious", 32'(spurious_resp), 32'h1);

        seen_load = 32'hxxxx_xxxx;
        applyStimulus(32'h0000_5001, 4'b0010, 4'b0000, 32'h0, LBU, 32'h0000_7F00, 2, 1'b0, 1'b0);
        checkOutput("post_reset_lbu", seen_load, 32'h0000_007F);
        idleCycles(2, 1'b0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
